// File: rtl/ic_ycbcr_ff_unpacker.sv
// ic_ycbcr_ff_unpacker: pops 64-bit colour FIFO words and serialises them into 8-bit samples with 8x8 block markers
module ic_ycbcr_ff_unpacker #(
  parameter int DATA_W      = 64,
  parameter int SAMPLE_W    = 8,
  parameter int LANES       = DATA_W / SAMPLE_W,
  parameter int BLOCK_WORDS = 8
) (
  input  logic                clock,
  input  logic                aclr,
  input  logic                sclr,
  input  logic                ff_empty,
  input  logic [DATA_W-1:0]   ff_q,
  output logic                ff_rdreq,
  output logic [SAMPLE_W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_sop,
  output logic                out_eop
);
  localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
  localparam int WW = BLOCK_WORDS > 1 ? $clog2(BLOCK_WORDS) : 1;
  logic [DATA_W-1:0] data_buf;
  logic              buf_valid;
  logic              rd_pend;
  logic [LW-1:0]     lane;
  logic [WW-1:0]     word;
  logic [LW-1:0]     cur_lane;
  logic [DATA_W-1:0] cur_word;
  logic              accept;
  logic              last_accept;
  // The word arriving on ff_q is presented straight away as lane 0, so a
  // read issued on the last accept refills the stream without a bubble.
  always_comb begin
    cur_lane    = rd_pend ? '0 : lane;
    cur_word    = rd_pend ? ff_q : data_buf;
    out_valid   = (buf_valid | rd_pend) & !sclr;
    out_data    = cur_word[cur_lane*SAMPLE_W +: SAMPLE_W];
    accept      = out_valid & out_ready;
    last_accept = accept & (cur_lane == LW'(LANES-1));
    out_sop     = out_valid & (word == '0) & (cur_lane == '0);
    out_eop     = out_valid & (word == WW'(BLOCK_WORDS-1)) & (cur_lane == LW'(LANES-1));
    ff_rdreq    = !ff_empty & !rd_pend & (!buf_valid | last_accept) & !sclr & !aclr;
  end
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      data_buf  <= '0;
      buf_valid <= 1'b0;
      rd_pend   <= 1'b0;
      lane      <= '0;
      word      <= '0;
    end else if (sclr) begin
      buf_valid <= 1'b0;
      rd_pend   <= 1'b0;
      lane      <= '0;
      word      <= '0;
    end else begin
      rd_pend <= ff_rdreq;
      if (rd_pend) begin
        data_buf  <= ff_q;
        buf_valid <= !last_accept;
        lane      <= LW'(accept);
      end else if (last_accept) buf_valid <= 1'b0;
      else if (accept) lane <= lane + 1'b1;
      if (last_accept) word <= (word == WW'(BLOCK_WORDS-1)) ? '0 : word + 1'b1;
    end
  end
endmodule

// File: tb/tb_ic_ycbcr_ff_unpacker.sv
// tb_ic_ycbcr_ff_unpacker: directed and random checks of the FIFO unpacker against a byte-stream model
module tb_ic_ycbcr_ff_unpacker;
  logic        clock = 0;
  logic        aclr = 1;
  logic        sclr = 0;
  logic        ff_empty = 1;
  logic [63:0] ff_q = '0;
  logic        ff_rdreq;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 0;
  logic        out_sop;
  logic        out_eop;
  int checks = 0;
  int failures = 0;
  logic [63:0] fifo[$];
  logic [7:0]  exp_q[$];
  int pos = 0;
  int n_rd = 0;
  int n_acc = 0;
  logic p_valid = 0, p_ready = 0, p_sclr = 0, p_sop = 0, p_eop = 0, p_rd = 0;
  logic [7:0] p_data = '0;
  logic [63:0] w3, w4, w5;
  logic [3:0] pat = 4'b1001;

  always #5 clock = ~clock;

  ic_ycbcr_ff_unpacker dut (
    .clock(clock), .aclr(aclr), .sclr(sclr), .ff_empty(ff_empty), .ff_q(ff_q),
    .ff_rdreq(ff_rdreq), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check the settled outputs, then let the FIFO model react to the edge.
  task automatic cyc(input logic rdy, input logic sc);
    logic acc;
    logic rq;
    @(negedge clock);
    out_ready = rdy;
    sclr = sc;
    ff_empty = (fifo.size() == 0);
    #1;
    acc = out_valid & rdy;
    rq = ff_rdreq;
    if (ff_empty) chk("no_read_when_empty", ff_rdreq, 0);
    if (sc) chk("no_read_during_sclr", ff_rdreq, 0);
    else begin
      if (p_valid && !p_ready && !p_sclr) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, p_data);
        chk("stall_sop", out_sop, p_sop);
        chk("stall_eop", out_eop, p_eop);
      end
      if (out_valid && exp_q.size() == 0) chk("valid_without_data", out_valid, 0);
      else if (out_valid) begin
        chk("data", out_data, exp_q[0]);
        chk("sop", out_sop, (pos % 64) == 0);
        chk("eop", out_eop, (pos % 64) == 63);
      end
      if (ff_rdreq && out_valid) chk("read_only_on_lane7_accept", acc && (pos % 8) == 7, 1);
      if (ff_rdreq) n_rd++;
      if (acc) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        pos++;
        n_acc++;
      end
    end
    p_valid = out_valid;
    p_ready = rdy;
    p_sclr = sc;
    p_sop = out_sop;
    p_eop = out_eop;
    p_data = out_data;
    p_rd = rq;
    @(posedge clock);
    #1;
    if (sc) begin
      fifo.delete();
      exp_q.delete();
      pos = 0;
    end else if (rq && fifo.size() > 0) begin
      ff_q = fifo.pop_front();
      for (int b = 0; b < 8; b++) exp_q.push_back(ff_q[8*b +: 8]);
    end
    ff_empty = (fifo.size() == 0);
  endtask

  task automatic do_aclr();
    aclr = 1;
    #1;
    chk("aclr_valid", out_valid, 0);
    chk("aclr_rdreq", ff_rdreq, 0);
    chk("aclr_sop", out_sop, 0);
    chk("aclr_eop", out_eop, 0);
    chk("aclr_data", out_data, 0);
    exp_q.delete();
    pos = 0;
    p_valid = 0;
    p_sclr = 0;
    @(posedge clock);
    #2 aclr = 0;
  endtask

  initial begin
    fifo.push_back(64'h0706050403020100);
    ff_empty = 0;
    #12;
    do_aclr();
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0);
      chk("single_rdreq", p_rd, i == 0);
      chk("single_valid", p_valid, i >= 1 && i <= 8);
      if (i >= 1 && i <= 8) chk("single_data", p_data, i - 1);
      if (i == 1) chk("single_sop", p_sop, 1);
    end

    do_aclr();
    for (int i = 0; i < 8; i++) fifo.push_back({$urandom, $urandom});
    n_rd = 0;
    n_acc = 0;
    for (int i = 0; i < 65; i++) begin
      cyc(1, 0);
      if (i == 0) chk("block_first_rdreq", p_rd, 1);
      chk("block_gapless", p_valid, i >= 1);
      if (i == 64) chk("block_eop", p_eop, 1);
    end
    chk("block_samples", n_acc, 64);
    chk("block_reads", n_rd, 8);
    fifo.push_back({$urandom, $urandom});
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0);
      if (i == 1) chk("wrap_sop", p_sop, 1);
    end
    chk("wrap_count", pos, 72);

    do_aclr();
    for (int i = 0; i < 8; i++) fifo.push_back({$urandom, $urandom});
    n_acc = 0;
    for (int i = 0; i < 400 && n_acc < 64; i++) cyc(pat[i % 4], 0);
    chk("backpressure_samples", n_acc, 64);
    chk("backpressure_leftover", exp_q.size(), 0);

    do_aclr();
    fifo.push_back({$urandom, $urandom});
    fifo.push_back({$urandom, $urandom});
    cyc(1, 0);
    chk("sclr_read_issued", p_rd, 1);
    cyc(1, 1);
    w3 = {$urandom, $urandom};
    fifo.push_back(w3);
    cyc(1, 0);
    chk("sclr_valid_after", p_valid, 0);
    cyc(1, 0);
    chk("sclr_next_valid", p_valid, 1);
    chk("sclr_next_sop", p_sop, 1);
    chk("sclr_next_data", p_data, w3[7:0]);
    for (int i = 0; i < 10; i++) cyc(1, 0);

    w4 = {$urandom, $urandom};
    w5 = {$urandom, $urandom};
    fifo.push_back(w4);
    fifo.push_back(w5);
    for (int i = 0; i < 4; i++) cyc(1, 0);
    cyc(0, 0);
    chk("mid_lane3_data", p_data, w4[31:24]);
    do_aclr();
    cyc(1, 0);
    cyc(1, 0);
    chk("aclr_next_valid", p_valid, 1);
    chk("aclr_next_sop", p_sop, 1);
    chk("aclr_next_data", p_data, w5[7:0]);
    for (int i = 0; i < 10; i++) cyc(1, 0);

    do_aclr();
    for (int i = 0; i < 1500; i++) begin
      if (fifo.size() < 16 && $urandom_range(0, 2) == 0) fifo.push_back({$urandom, $urandom});
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
    end
    for (int i = 0; i < 300 && (fifo.size() + exp_q.size()) > 0; i++) cyc(1, 0);
    chk("random_drained", fifo.size() + exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
